// File: rtl/accel_pkg.sv
// Shared constants for the accelerator: array geometry, one-hot sequencer
// states and SRAM control polarities.
package accel_pkg;

  localparam int DIM    = 16;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 128;

  // One-hot sequencer states, as seen on the STATE output
  localparam logic [5:0] ST_IDLE   = 6'b000001;
  localparam logic [5:0] ST_LOAD_W = 6'b000010;
  localparam logic [5:0] ST_STREAM = 6'b000100;
  localparam logic [5:0] ST_DRAIN  = 6'b001000;
  localparam logic [5:0] ST_WRITE  = 6'b010000;
  localparam logic [5:0] ST_DONE   = 6'b100000;

  typedef enum logic [5:0] {
    S_IDLE   = ST_IDLE,
    S_LOAD_W = ST_LOAD_W,
    S_STREAM = ST_STREAM,
    S_DRAIN  = ST_DRAIN,
    S_WRITE  = ST_WRITE,
    S_DONE   = ST_DONE
  } seq_state_e;

  // SRAM chip/write enables are active-low
  localparam logic SRAM_ASSERT   = 1'b0;
  localparam logic SRAM_DEASSERT = 1'b1;

endpackage

// File: rtl/systolic_sequencer.sv
// Tile-pass sequencer for the systolic array: loads weights, streams
// activations, waits for the array to drain, then writes the output rows
// back to the shared single-port SRAM.
//
// Every output is a register. k_q holds the index of the next row to issue
// in the current phase; the edge that issues a row also presents it on the
// SRAM pins for the following cycle. k_q == DIM marks a completed phase, so
// the next enabled edge moves straight into the following phase.
module systolic_sequencer
  import accel_pkg::*;
#(
  parameter int DIM       = 16,
  parameter int ADDR_W    = 13,
  parameter int DRAIN_CYC = 2 * DIM
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   EN,
  input  logic [ADDR_W-1:0]      IADDR,
  input  logic [ADDR_W-1:0]      WADDR,
  input  logic [ADDR_W-1:0]      OADDR,
  output logic                   share_cen,
  output logic                   share_wen,
  output logic                   share_ren,
  output logic [ADDR_W-1:0]      share_addr,
  output logic                   W_EN,
  output logic                   A_VALID,
  output logic                   SELECTOR,
  output logic [$clog2(DIM)-1:0] OUT_ROW,
  output logic [5:0]             STATE,
  output logic                   BUSY
);

  localparam int RW = $clog2(DIM);
  localparam int KW = RW + 1;
  localparam int DW = $clog2(DRAIN_CYC + 1);
  localparam logic [KW-1:0] K_END = KW'(DIM);

  seq_state_e      state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic [ADDR_W-1:0] ibase_q, ibase_d;
  logic [ADDR_W-1:0] wbase_q, wbase_d;
  logic [ADDR_W-1:0] obase_q, obase_d;
  logic            cen_q, cen_d;
  logic            wen_q, wen_d;
  logic            ren_q, ren_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic            w_en_q, w_en_d;
  logic            a_valid_q, a_valid_d;
  logic            sel_q, sel_d;
  logic [RW-1:0]   out_row_q, out_row_d;
  logic            busy_q, busy_d;

  // Next-state and next-output logic; SRAM idles unless a row is issued
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    drain_d   = drain_q;
    ibase_d   = ibase_q;
    wbase_d   = wbase_q;
    obase_d   = obase_q;
    cen_d     = SRAM_DEASSERT;
    wen_d     = SRAM_DEASSERT;
    ren_d     = 1'b0;
    addr_d    = addr_q;
    sel_d     = 1'b0;
    out_row_d = out_row_q;
    // Read data arrives one cycle after the issue; tag it by phase
    w_en_d    = (state_q == S_LOAD_W) && ren_q;
    a_valid_d = (state_q == S_STREAM) && ren_q;

    unique case (state_q)
      S_IDLE: begin
        if (EN) begin
          ibase_d = IADDR;
          wbase_d = WADDR;
          obase_d = OADDR;
          state_d = S_LOAD_W;
          addr_d  = WADDR;
          cen_d   = SRAM_ASSERT;
          ren_d   = 1'b1;
          k_d     = KW'(1);
        end
      end
      S_LOAD_W: begin
        if (EN) begin
          cen_d = SRAM_ASSERT;
          ren_d = 1'b1;
          if (k_q == K_END) begin
            state_d = S_STREAM;
            addr_d  = ibase_q;
            k_d     = KW'(1);
          end else begin
            addr_d = wbase_q + ADDR_W'(k_q);
            k_d    = k_q + KW'(1);
          end
        end
      end
      S_STREAM: begin
        if (EN) begin
          if (k_q == K_END) begin
            state_d = S_DRAIN;
            drain_d = DW'(1);
            k_d     = '0;
          end else begin
            cen_d  = SRAM_ASSERT;
            ren_d  = 1'b1;
            addr_d = ibase_q + ADDR_W'(k_q);
            k_d    = k_q + KW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (EN) begin
          if (drain_q == DW'(DRAIN_CYC)) begin
            state_d   = S_WRITE;
            cen_d     = SRAM_ASSERT;
            wen_d     = SRAM_ASSERT;
            addr_d    = obase_q;
            sel_d     = 1'b1;
            out_row_d = '0;
            k_d       = KW'(1);
          end else begin
            drain_d = drain_q + DW'(1);
          end
        end
      end
      S_WRITE: begin
        // The array keeps driving write data through a pause
        sel_d = 1'b1;
        if (EN) begin
          if (k_q == K_END) begin
            state_d = S_DONE;
            sel_d   = 1'b0;
          end else begin
            cen_d     = SRAM_ASSERT;
            wen_d     = SRAM_ASSERT;
            addr_d    = obase_q + ADDR_W'(k_q);
            out_row_d = k_q[RW-1:0];
            k_d       = k_q + KW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        k_d     = '0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State, counters, bases and output registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      drain_q   <= '0;
      ibase_q   <= '0;
      wbase_q   <= '0;
      obase_q   <= '0;
      cen_q     <= SRAM_DEASSERT;
      wen_q     <= SRAM_DEASSERT;
      ren_q     <= 1'b0;
      addr_q    <= '0;
      w_en_q    <= 1'b0;
      a_valid_q <= 1'b0;
      sel_q     <= 1'b0;
      out_row_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      drain_q   <= drain_d;
      ibase_q   <= ibase_d;
      wbase_q   <= wbase_d;
      obase_q   <= obase_d;
      cen_q     <= cen_d;
      wen_q     <= wen_d;
      ren_q     <= ren_d;
      addr_q    <= addr_d;
      w_en_q    <= w_en_d;
      a_valid_q <= a_valid_d;
      sel_q     <= sel_d;
      out_row_q <= out_row_d;
      busy_q    <= busy_d;
    end
  end

  assign STATE      = state_q;
  assign share_cen  = cen_q;
  assign share_wen  = wen_q;
  assign share_ren  = ren_q;
  assign share_addr = addr_q;
  assign W_EN       = w_en_q;
  assign A_VALID    = a_valid_q;
  assign SELECTOR   = sel_q;
  assign OUT_ROW    = out_row_q;
  assign BUSY       = busy_q;

endmodule

// File: tb/tb_systolic_sequencer.sv
// Directed bench for systolic_sequencer: expected SRAM accesses go into a
// scoreboard queue when a pass is launched and are popped as the sequencer
// issues them; per-cycle state, strobes and pass length are checked too.
module tb_systolic_sequencer;

  logic        CLK;
  logic        RESET;
  logic        EN;
  logic [12:0] IADDR, WADDR, OADDR;
  logic        share_cen, share_wen, share_ren;
  logic [12:0] share_addr;
  logic        W_EN, A_VALID, SELECTOR;
  logic [3:0]  OUT_ROW;
  logic [5:0]  STATE;
  logic        BUSY;

  int vectors;
  int miscompares;

  typedef struct packed {
    logic [1:0]  kind;  // 0 weight read, 1 activation read, 2 write
    logic [12:0] addr;
    logic [3:0]  row;
  } acc_t;

  acc_t exp_q[$];

  systolic_sequencer #(.DIM(16), .ADDR_W(13), .DRAIN_CYC(32)) dut (
    .CLK(CLK), .RESET(RESET), .EN(EN),
    .IADDR(IADDR), .WADDR(WADDR), .OADDR(OADDR),
    .share_cen(share_cen), .share_wen(share_wen), .share_ren(share_ren),
    .share_addr(share_addr), .W_EN(W_EN), .A_VALID(A_VALID),
    .SELECTOR(SELECTOR), .OUT_ROW(OUT_ROW), .STATE(STATE), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One tile pass. pause_c: EN is low for the pause_len edges that end
  // cycles pause_c.. (0 = no pause). chg_c: cycle at which the base inputs
  // are scrambled (0 = never). keep_en leaves EN high after the pass.
  task automatic run_pass(input logic [12:0] ia, input logic [12:0] wa,
                          input logic [12:0] oa, input int pause_c,
                          input int pause_len, input int chg_c,
                          input bit keep_en);
    int p;
    int busy_cnt;
    int prev_kind;
    int cur_kind;
    bit done;
    logic [5:0] exp_state;
    bit exp_acc;
    acc_t e;
    p = (pause_c > 0) ? pause_len : 0;
    for (int k = 0; k < 16; k++) exp_q.push_back('{2'd0, wa + 13'(k), 4'd0});
    for (int k = 0; k < 16; k++) exp_q.push_back('{2'd1, ia + 13'(k), 4'd0});
    for (int k = 0; k < 16; k++) exp_q.push_back('{2'd2, oa + 13'(k), 4'(k)});
    IADDR = ia; WADDR = wa; OADDR = oa; EN = 1'b1;
    busy_cnt = 0; prev_kind = 3; done = 0;
    @(posedge CLK); #1;
    for (int c = 1; c <= 200 && !done; c++) begin
      if (BUSY) busy_cnt++;
      if (c <= 16)          exp_state = 6'b000010;
      else if (c <= 32 + p) exp_state = 6'b000100;
      else if (c <= 64 + p) exp_state = 6'b001000;
      else if (c <= 80 + p) exp_state = 6'b010000;
      else if (c == 81 + p) exp_state = 6'b100000;
      else                  exp_state = 6'b000001;
      check($sformatf("state_c%0d", c), 32'(STATE), 32'(exp_state));
      exp_acc = (exp_state == 6'b000010 || exp_state == 6'b000100 ||
                 exp_state == 6'b010000) &&
                !(pause_c > 0 && c > pause_c && c <= pause_c + pause_len);
      check($sformatf("cen_c%0d", c), 32'(share_cen), 32'(!exp_acc));
      check($sformatf("w_en_c%0d", c), 32'(W_EN), 32'(prev_kind == 0));
      check($sformatf("a_valid_c%0d", c), 32'(A_VALID), 32'(prev_kind == 1));
      check($sformatf("excl_c%0d", c), 32'(W_EN && A_VALID), 32'(0));
      cur_kind = 3;
      if (share_cen == 1'b0) begin
        if (exp_q.size() == 0) begin
          check($sformatf("unexpected_access_c%0d", c), 32'(1), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check($sformatf("addr_c%0d", c), 32'(share_addr), 32'(e.addr));
          if (e.kind == 2'd2) begin
            check($sformatf("wen_c%0d", c), 32'(share_wen), 32'(0));
            check($sformatf("ren_c%0d", c), 32'(share_ren), 32'(0));
            check($sformatf("sel_c%0d", c), 32'(SELECTOR), 32'(1));
            check($sformatf("out_row_c%0d", c), 32'(OUT_ROW), 32'(e.row));
          end else begin
            check($sformatf("wen_c%0d", c), 32'(share_wen), 32'(1));
            check($sformatf("ren_c%0d", c), 32'(share_ren), 32'(1));
            cur_kind = int'(e.kind);
          end
        end
      end
      prev_kind = cur_kind;
      if (chg_c > 0 && c == chg_c) begin
        IADDR = ~ia; WADDR = ~wa; OADDR = ~oa;
      end
      if (c == 82 + p) begin
        done = 1;
        if (!keep_en) EN = 1'b0;
      end else begin
        EN = !(pause_c > 0 && c >= pause_c && c < pause_c + pause_len);
        @(posedge CLK); #1;
      end
    end
    check("pass_completed", 32'(done), 32'(1));
    check("busy_len", 32'(busy_cnt), 32'(81 + p));
    check("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("pass I=%0d W=%0d O=%0d pause=%0d busy=%0d", ia, wa, oa, p, busy_cnt);
    exp_q.delete();
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    RESET = 1'b0; EN = 1'b0; IADDR = '0; WADDR = '0; OADDR = '0;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b1;
    @(posedge CLK); #1;
    check("rst_state", 32'(STATE), 32'(1));
    check("rst_cen", 32'(share_cen), 32'(1));
    check("rst_wen", 32'(share_wen), 32'(1));
    check("rst_ren", 32'(share_ren), 32'(0));
    check("rst_addr", 32'(share_addr), 32'(0));
    check("rst_out_row", 32'(OUT_ROW), 32'(0));
    check("rst_strobes", 32'({W_EN, A_VALID, SELECTOR, BUSY}), 32'(0));
    $display("reset values checked");

    // Nominal pass
    run_pass(13'd0, 13'd16, 13'd31, 0, 0, 0, 1'b0);
    @(posedge CLK); #1;
    check("idle_after_pass", 32'(STATE), 32'(1));

    // Output address wrap-around
    run_pass(13'd100, 13'd200, 13'd8190, 0, 0, 0, 1'b0);

    // Pause for three edges at activation row 5
    run_pass(13'd40, 13'd300, 13'd500, 21, 3, 0, 1'b0);

    // Base inputs change during LOAD_W
    run_pass(13'd1000, 13'd2000, 13'd3000, 0, 0, 5, 1'b0);

    // Back-to-back passes with EN held high
    run_pass(13'd7, 13'd70, 13'd700, 0, 0, 0, 1'b1);
    run_pass(13'd8000, 13'd8180, 13'd4000, 0, 0, 0, 1'b0);

    // Asynchronous reset in STREAM row 0 (W_EN still high for last weight)
    @(posedge CLK); #1;
    IADDR = 13'd10; WADDR = 13'd20; OADDR = 13'd30; EN = 1'b1;
    @(posedge CLK);
    repeat (16) @(posedge CLK);
    #1;
    check("pre_rst_state", 32'(STATE), 32'(6'b000100));
    check("pre_rst_w_en", 32'(W_EN), 32'(1));
    #2 RESET = 1'b0;
    #1;
    check("async_rst_state", 32'(STATE), 32'(1));
    check("async_rst_cen", 32'(share_cen), 32'(1));
    check("async_rst_w_en", 32'(W_EN), 32'(0));
    check("async_rst_busy", 32'(BUSY), 32'(0));
    EN = 1'b0;
    #10 RESET = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("post_rst_state", 32'(STATE), 32'(1));
    check("post_rst_cen", 32'(share_cen), 32'(1));
    check("post_rst_busy", 32'(BUSY), 32'(0));
    $display("async reset mid-stream checked");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/systolic_sequencer.md
# systolic_sequencer

Top-level sequencer for the 16×16 systolic array inside `Accelerator`. It owns the single-port shared SRAM and drives the array's load controls. On a start request it performs one tile pass: load weights, stream activations, drain the array, write the outputs back. Base addresses come from the `IADDR`/`WADDR`/`OADDR` inputs.

## Interface
- `DIM`, 16: array dimension; rows per phase.
- `ADDR_W`, 13: shared-SRAM address width.
- `DRAIN_CYC`, 2*DIM: wait cycles between the last activation and output write-back.
- `CLK`  in  1  clock; all logic on the rising edge.
- `RESET`  in  1  reset, asynchronous and active-low; 0 forces the reset state immediately.
- `EN`  in  1  start when IDLE; hold-low pauses an active pass.
- `IADDR`  in  ADDR_W  activation base address, latched at start.
- `WADDR`  in  ADDR_W  weight base address, latched at start.
- `OADDR`  in  ADDR_W  output base address, latched at start.
- `share_cen`  out  1  SRAM chip enable, active-low.
- `share_wen`  out  1  SRAM write enable, active-low (0 = write).
- `share_ren`  out  1  SRAM read strobe, active-high.
- `share_addr`  out  ADDR_W  SRAM address.
- `W_EN`  out  1  array latches the SRAM read data as a weight row.
- `A_VALID`  out  1  SRAM read data is a valid activation row.
- `SELECTOR`  out  1  1 = array output row drives SRAM write data; 0 = SRAM read data drives the array.
- `OUT_ROW`  out  $clog2(DIM)  array output row selected for write-back.
- `STATE`  out  6  one-hot state: bit0 IDLE, bit1 LOAD_W, bit2 STREAM, bit3 DRAIN, bit4 WRITE, bit5 DONE.
- `BUSY`  out  1  high in every state except IDLE.

## Operation
- **Reset values:**
  - `STATE` = 6'b000001.
  - `share_cen` = 1, `share_wen` = 1, `share_ren` = 0.
  - `share_addr`, `OUT_ROW`, row counter and latched bases = 0.
  - `W_EN`, `A_VALID`, `SELECTOR`, `BUSY` = 0.
- **IDLE:** when `EN`=1 at an edge, latch the three bases, clear row counter `k`, go to LOAD_W.
- **LOAD_W** (k = 0..DIM-1): `share_addr` = WADDR+k, `share_cen`=0, `share_ren`=1. Go to STREAM after k = DIM-1, clearing `k`.
- **STREAM** (k = 0..DIM-1): same as LOAD_W with `share_addr` = IADDR+k. Go to DRAIN after k = DIM-1.
- **DRAIN:** count DRAIN_CYC cycles with SRAM idle (`share_cen`=1), then go to WRITE.
- **WRITE** (k = 0..DIM-1): `SELECTOR`=1, `OUT_ROW`=k, `share_addr`=OADDR+k, `share_cen`=0, `share_wen`=0. Go to DONE after k = DIM-1.
- **DONE:** one cycle, then IDLE. `EN` still high in IDLE starts a new pass.
- **Address arithmetic:** ADDR_W bits, modulo 2^ADDR_W, so OADDR=8191 with k=1 gives 0. Base inputs are ignored after the latch.
- **Pause:** `EN`=0 in LOAD_W, STREAM, DRAIN or WRITE freezes `k` and the drain counter and forces `share_cen`=1, `share_ren`=0, `share_wen`=1. A read issued in the previous cycle still produces its `W_EN`/`A_VALID` strobe. Resume continues at the same `k`. `EN` is ignored in DONE.
- **Mutual exclusion:** `W_EN` and `A_VALID` are never high in the same cycle. `share_ren` and a write are never active together.

## Timing
- SRAM read latency is 1 cycle. `W_EN`/`A_VALID` are registered copies of the read issue for that phase, delayed by one cycle.
  - The last `W_EN` falls in STREAM k=0.
  - The last `A_VALID` falls in the first DRAIN cycle.
- Writes take effect at the edge that ends the WRITE cycle. `SELECTOR` and `OUT_ROW` are valid in that same cycle.
- With no pause, a pass lasts DIM + DIM + DRAIN_CYC + DIM + 1 cycles after the start edge (81 with defaults). `BUSY` is high for exactly those cycles.
- All outputs are registered. There is no combinational path from `EN` or the base inputs to any output.
- **Asynchronous reset mid-pass:** outputs go to their reset values immediately and no partial write completes afterwards. The pass is not resumed after reset release.

## Structure
- Shared package `accel_pkg` holds:
  - the one-hot state localparams;
  - `DIM`, `ADDR_W`, `DATA_W` (128);
  - the SRAM active-low polarity constants.
  `Accelerator` and the array use the same package.
- Single module with one FSM register, one row counter, one drain counter and three base registers. No sub-module is required.

## Test plan
- **Reset:** hold `RESET`=0 mid-STREAM → `STATE`=1, `share_cen`=1, `W_EN`=0, all at once without waiting for a clock edge. After release the block stays IDLE with `EN`=0.
- **Nominal pass:** IADDR=0, WADDR=16, OADDR=31, pulse `EN` → exact expected sequence:
  - reads 16..31, with `W_EN` high for 16 cycles;
  - reads 0..15, with `A_VALID` high for 16 cycles;
  - 32 idle cycles;
  - writes to 31..46 with `OUT_ROW` 0..15;
  - `DONE` for one cycle; total 81 cycles.
- **Wrap-around:** OADDR=8190 → write addresses 8190, 8191, 0, 1, …, 13.
- **Pause:** drop `EN` for 3 cycles at STREAM k=5 → one trailing `A_VALID` (row 4), then `share_cen`=1 for 3 cycles, then resume at IADDR+5. Total pass length is 84 cycles.
- **Base change mid-pass:** change WADDR during LOAD_W → addresses unaffected.
- **Back-to-back:** hold `EN`=1 → second LOAD_W starts the cycle after IDLE. `W_EN`/`A_VALID` never overlap (assertion).
